// File: rtl/vend_dispense_ctrl.sv
// Vend/change dispense controller: queues sale transactions and sequences one
// product-release strobe followed by one hopper strobe per returned coin.
module vend_dispense_ctrl #(
  parameter int DEPTH   = 4,
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sell,
  input  logic [1:0]               change,
  output logic                     vend_fire,
  input  logic                     vend_done,
  output logic                     coin_fire,
  input  logic                     coin_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     fault,
  input  logic                     fault_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int MAXC = (TIMEOUT > PULSE_W) ? TIMEOUT : PULSE_W;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND_PULSE,
    S_VEND_WAIT,
    S_COIN_PULSE,
    S_COIN_WAIT,
    S_FAULT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_count;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_coins;
  logic            r_vend_fire;
  logic            r_coin_fire;
  logic            r_busy;
  logic            r_overflow;
  logic            r_fault;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic            w_pulse_end;
  logic            w_to_end;

  assign w_full      = (r_count == PW'(DEPTH));
  assign w_push      = sell && (!w_full || w_pop);
  assign w_pulse_end = (r_cnt == CW'(PULSE_W - 1));
  assign w_to_end    = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:       if (r_count != '0) w_next = S_VEND_PULSE;
      S_VEND_PULSE: if (w_pulse_end) w_next = S_VEND_WAIT;
      S_VEND_WAIT: begin
        if (vend_done) begin
          if (r_coins != '0) begin
            w_next = S_COIN_PULSE;
          end else begin
            w_next = S_IDLE;
            w_pop  = 1'b1;
          end
        end else if (w_to_end) begin
          w_next = S_FAULT;
        end
      end
      S_COIN_PULSE: if (w_pulse_end) w_next = S_COIN_WAIT;
      S_COIN_WAIT: begin
        // r_coins==1 here means this acknowledge returns the last coin
        if (coin_done) begin
          if (r_coins != 2'd1) begin
            w_next = S_COIN_PULSE;
          end else begin
            w_next = S_IDLE;
            w_pop  = 1'b1;
          end
        end else if (w_to_end) begin
          w_next = S_FAULT;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          w_next = S_IDLE;
          w_pop  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= change;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cnt       <= '0;
      r_coins     <= '0;
      r_vend_fire <= 1'b0;
      r_coin_fire <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;

      // One counter serves both strobe width and acknowledge timeout
      if (w_next != r_state || r_state == S_IDLE || r_state == S_FAULT)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);

      if (r_state == S_IDLE && w_next == S_VEND_PULSE)
        r_coins <= r_mem[r_rd_ptr];
      else if (r_state == S_COIN_WAIT && coin_done)
        r_coins <= r_coins - 2'd1;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase

      if (sell && w_full && !w_pop)
        r_overflow <= 1'b1;
      else if (fault_clr)
        r_overflow <= 1'b0;

      r_vend_fire <= (w_next == S_VEND_PULSE);
      r_coin_fire <= (w_next == S_COIN_PULSE);
      r_busy      <= (w_next != S_IDLE);
      r_fault     <= (w_next == S_FAULT);
    end
  end

  assign vend_fire = r_vend_fire;
  assign coin_fire = r_coin_fire;
  assign busy      = r_busy;
  assign pending   = r_count;
  assign overflow  = r_overflow;
  assign fault     = r_fault;

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Consumer side of the vending machine's sell/change outputs. Each cycle-wide sell pulse, with its change code, becomes a queued vend transaction.
- Per transaction: one product-release actuator strobe, then N coin-return hopper strobes. Each strobe is acknowledged by a done handshake from the mechanism.
- Sits between the vending FSM and the electromechanical drivers. Buffers back-to-back sales while the mechanism is slow.

Parameters:
- DEPTH, 4: pending-transaction queue depth; power of two, ≥2.
- PULSE_W, 4: actuator strobe width in clk cycles; ≥1.
- TIMEOUT, 255: max cycles waiting for a done acknowledge before fault; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- sell  in  1  one-cycle sale pulse from vending FSM.
- change  in  2  coins to return with this sale, 0..3; sampled only when sell=1.
- vend_fire  out  1  product-release strobe.
- vend_done  in  1  product-release acknowledge (level or pulse).
- coin_fire  out  1  coin-return hopper strobe, one strobe per coin.
- coin_done  in  1  hopper acknowledge for one coin.
- busy  out  1  FSM not in IDLE.
- pending  out  clog2(DEPTH)+1  queued transactions, including the one in service.
- overflow  out  1  sticky: a sale was dropped because the queue was full.
- fault  out  1  sticky: acknowledge timeout.
- fault_clr  in  1  clears fault and overflow; releases the FSM from FAULT.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on rising clk; rst has priority over every other input.
- Reset values:
  - Queue empty; pending=0.
  - FSM=IDLE; all counters 0.
  - vend_fire=0, coin_fire=0, busy=0, overflow=0, fault=0.
- All outputs are registered.
- Enqueue:
  - When sell=1 at an edge, push {change} into the FIFO.
  - change is ignored when sell=0.
- Full queue:
  - A sell arriving with the queue full, and no pop on the same edge, is dropped and sets overflow.
  - If a pop occurs on the same edge, the push succeeds; pending is unchanged.
- Dequeue: the head entry is popped on the edge that leaves the transaction (return to IDLE, or exit from FAULT).
- pending tracks push/pop exactly, including simultaneous push+pop.
- FSM states and transitions:
  - IDLE: if queue non-empty, load coin counter with the head's change value and go to VEND_PULSE.
  - VEND_PULSE: vend_fire=1 for exactly PULSE_W cycles, then go to VEND_WAIT.
  - VEND_WAIT: on vend_done=1, go to COIN_PULSE if coin counter>0, else pop and go to IDLE.
  - COIN_PULSE: coin_fire=1 for exactly PULSE_W cycles, then go to COIN_WAIT.
  - COIN_WAIT: on coin_done=1, decrement the coin counter. If the result is >0, go to COIN_PULSE; else pop and go to IDLE.
  - FAULT: set fault on entry; no strobes. On fault_clr=1, drop (pop) the head entry, clear fault and overflow, and go to IDLE.
- Handshake rules:
  - Done inputs are sampled only in the matching WAIT state; done asserted during PULSE or IDLE is ignored.
  - Each WAIT entry resets the timeout counter.
- Timeout: if a WAIT state persists for TIMEOUT cycles without its done, go to FAULT.
- Latency:
  - sell sampled at edge N gives pending=1 after N.
  - With the FSM idle, vend_fire rises after edge N+1.
  - The IDLE→next-transaction gap is one cycle (IDLE is always visited between transactions).
- During FAULT, the queue keeps accepting sells; overflow still applies.
- fault_clr outside FAULT clears overflow only.
- busy=1 in every state except IDLE.

Test Plan:
- Single sale, sell=1 with change=0, vend_done 3 cycles after vend_fire falls:
  - vend_fire high 4 cycles, starting 2 cycles after sell.
  - No coin_fire.
  - pending 1→0 on return to IDLE.
- Sale with change=2, immediate acknowledges:
  - One vend strobe, then exactly two coin_fire strobes of 4 cycles each.
  - busy drops after the second coin_done.
- Five back-to-back sells (DEPTH=4) while the first is in VEND_WAIT:
  - pending saturates at 4; overflow=1 after the 5th.
  - Four transactions serviced in order, with the change values preserved.
- Push while full on the same edge as a pop:
  - pending stays 4; overflow remains 0.
- No vend_done for 255 cycles:
  - fault=1, FSM in FAULT, no strobes.
  - fault_clr drops the entry; the next queued sale starts one cycle after IDLE.
- rst asserted mid-COIN_PULSE:
  - Next cycle coin_fire=0, pending=0, busy=0, fault=0.
  - A sell after reset is serviced normally.
